mips_arith_sequencer: RTL and testbench

Multi-cycle controller that sequences the arithmetic datapath: fetches 32-bit instructions over a ready/request memory handshake, presents opcode/funct to the instruction decoder, allows one ALU settle cycle, then pulses the register-file write enable. It sits between instruction memory and the decoder/ALU/register-file datapath and owns the PC. It halts on decoder exceptions and on fetch timeouts.

---
 rtl/mips_arith_sequencer.sv | 169 ++++++++++++++++
 tb/tb_mips_arith_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_arith_sequencer.sv
// mips_arith_sequencer
// Multi-cycle controller for the arithmetic datapath. It owns the PC, fetches
// 32-bit instructions over a request/ready handshake, lets the decoder look at
// the IR for one cycle, allows one ALU settle cycle, then strobes the
// register-file write enable. Decoder exceptions and fetch timeouts park the
// machine in HALT until reset.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   start, stop             leave IDLE / return to IDLE after current WB
//   imem_req/addr/ready/data instruction memory handshake (addr = pc)
//   dec_opcode, dec_funct   ir fields presented to the decoder
//   dec_writeenable/except  decoder responses
//   rf_we                   register-file write strobe (WB only)
//   ir, pc                  instruction register, word-addressed PC
//   busy, halted            FETCH..WB / HALT status
//   halt_cause, exc_pc      0 none, 1 illegal instr, 2 fetch timeout; faulting pc
//   instr_count             retired instruction count
//
// Build option: define ICOUNT_EN to build the retired-instruction counter;
// otherwise instr_count reads as zero.

module mips_arith_sequencer #(
    parameter int                    PC_WIDTH = 30,
    parameter logic [PC_WIDTH-1:0]   RESET_PC = '0,
    parameter int                    MAX_WAIT = 15
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ready,
    input  logic [31:0]         imem_data,
    output logic [5:0]          dec_opcode,
    output logic [5:0]          dec_funct,
    input  logic                dec_writeenable,
    input  logic                dec_except,
    output logic                rf_we,
    output logic [31:0]         ir,
    output logic [PC_WIDTH-1:0] pc,
    output logic                busy,
    output logic                halted,
    output logic [1:0]          halt_cause,
    output logic [PC_WIDTH-1:0] exc_pc,
    output logic [31:0]         instr_count
);

    // state  | meaning
    // IDLE   | waiting for start
    // FETCH  | imem_req high, waiting for imem_ready (wait counter runs)
    // DECODE | decoder sees ir; exception halts here
    // EXEC   | ALU settle cycle
    // WB     | rf_we strobe, pc advance, stop sampled
    // HALT   | parked until reset

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
    } state_t;

    localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]         ir_q, ir_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [1:0]          halt_cause_q, halt_cause_d;
    logic [PC_WIDTH-1:0] exc_pc_q, exc_pc_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            ir_q         <= '0;
            wait_q       <= '0;
            halt_cause_q <= '0;
            exc_pc_q     <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            wait_q       <= wait_d;
            halt_cause_q <= halt_cause_d;
            exc_pc_q     <= exc_pc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        wait_d       = wait_q;
        halt_cause_d = halt_cause_q;
        exc_pc_d     = exc_pc_q;
        imem_req     = 1'b0;
        rf_we        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_d    = imem_data;
                    wait_d  = '0;
                    state_d = S_DECODE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                    // With MAX_WAIT == 0 the counter just wraps and is ignored.
                    if (MAX_WAIT != 0 && wait_d == WAIT_LIMIT) begin
                        state_d      = S_HALT;
                        halt_cause_d = 2'd2;
                        exc_pc_d     = pc_q;
                    end
                end
            end
            S_DECODE: begin
                if (dec_except) begin
                    state_d      = S_HALT;
                    halt_cause_d = 2'd1;
                    exc_pc_d     = pc_q;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_WB;
            end
            S_WB: begin
                rf_we   = dec_writeenable;
                pc_d    = pc_q + PC_WIDTH'(1);
                state_d = stop ? S_IDLE : S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef ICOUNT_EN
    logic [31:0] icount_q;

    always_ff @(posedge clock) begin
        if (reset)               icount_q <= '0;
        else if (state_q == S_WB) icount_q <= icount_q + 32'd1;
    end

    assign instr_count = icount_q;
`else
    assign instr_count = '0;
`endif

    assign imem_addr  = pc_q;
    assign dec_opcode = ir_q[31:26];
    assign dec_funct  = ir_q[5:0];
    assign ir         = ir_q;
    assign pc         = pc_q;
    assign busy       = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                        (state_q == S_EXEC)  || (state_q == S_WB);
    assign halted     = (state_q == S_HALT);
    assign halt_cause = halt_cause_q;
    assign exc_pc     = exc_pc_q;

endmodule

// File: tb/tb_mips_arith_sequencer.sv
module tb_mips_arith_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, start, stop, imem_ready;
    logic        start2, stop2;
    logic [31:0] mem [0:15];

    // main instance (defaults)
    logic        imem_req, dec_writeenable, dec_except, rf_we, busy, halted;
    logic [29:0] imem_addr, pc, exc_pc;
    logic [31:0] imem_data, ir, instr_count;
    logic [5:0]  dec_opcode, dec_funct;
    logic [1:0]  halt_cause;

    // narrow-PC instance, timeout disabled
    logic        imem_req2, dec_writeenable2, dec_except2, rf_we2, busy2, halted2;
    logic [3:0]  imem_addr2, pc2, exc_pc2;
    logic [31:0] imem_data2, ir2, instr_count2;
    logic [5:0]  dec_opcode2, dec_funct2;
    logic [1:0]  halt_cause2;

    // memory and decoder models: opcode 0x3F is illegal, everything else writes
    assign imem_data        = mem[imem_addr[3:0]];
    assign dec_except       = (dec_opcode == 6'h3F);
    assign dec_writeenable  = !dec_except;
    assign imem_data2       = mem[imem_addr2];
    assign dec_except2      = (dec_opcode2 == 6'h3F);
    assign dec_writeenable2 = !dec_except2;

    mips_arith_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_data(imem_data), .dec_opcode(dec_opcode), .dec_funct(dec_funct),
        .dec_writeenable(dec_writeenable), .dec_except(dec_except),
        .rf_we(rf_we), .ir(ir), .pc(pc), .busy(busy), .halted(halted),
        .halt_cause(halt_cause), .exc_pc(exc_pc), .instr_count(instr_count)
    );

    mips_arith_sequencer #(.PC_WIDTH(4), .RESET_PC(4'hF), .MAX_WAIT(0)) dut2 (
        .clock(clock), .reset(reset), .start(start2), .stop(stop2),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ready(imem_ready),
        .imem_data(imem_data2), .dec_opcode(dec_opcode2), .dec_funct(dec_funct2),
        .dec_writeenable(dec_writeenable2), .dec_except(dec_except2),
        .rf_we(rf_we2), .ir(ir2), .pc(pc2), .busy(busy2), .halted(halted2),
        .halt_cause(halt_cause2), .exc_pc(exc_pc2), .instr_count(instr_count2)
    );

    typedef struct {
        logic [29:0] pc;
        logic [31:0] ir;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   retired = 0;

    function automatic logic [31:0] exp_icount(input int n);
`ifdef ICOUNT_EN
        return 32'(n);
`else
        return 32'd0;
`endif
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; stop = 1'b0; imem_ready = 1'b0;
        start2 = 1'b0; stop2 = 1'b0;
        repeat (2) @(negedge clock);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0h want 0", busy); end
        n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL rst_halted: got %0h want 0", halted); end
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %0h want 0", imem_req); end
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL rst_we: got %0h want 0", rf_we); end
        n_cmp++; if (pc !== 30'd0) begin n_err++; $display("FAIL rst_pc: got %0h want 0", pc); end
        n_cmp++; if (ir !== 32'd0) begin n_err++; $display("FAIL rst_ir: got %0h want 0", ir); end
        n_cmp++; if (halt_cause !== 2'd0) begin n_err++; $display("FAIL rst_cause: got %0h want 0", halt_cause); end
        n_cmp++; if (exc_pc !== 30'd0) begin n_err++; $display("FAIL rst_excpc: got %0h want 0", exc_pc); end
        n_cmp++; if (instr_count !== 32'd0) begin n_err++; $display("FAIL rst_icount: got %0h want 0", instr_count); end
        n_cmp++; if (pc2 !== 4'hF) begin n_err++; $display("FAIL rst_pc2: got %0h want f", pc2); end
        reset = 1'b0;
    endtask

    task automatic test_add();
        exp_t e;
        int got = 0;
        mem[0] = 32'h012A4020; imem_ready = 1'b1; stop = 1'b1;
        sb.push_back('{pc: 30'd0, ir: 32'h012A4020});
        start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            if (c == 1) begin
                start = 1'b0;
                n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL add_req: got %0h want 1", imem_req); end
                n_cmp++; if (imem_addr !== 30'd0) begin n_err++; $display("FAIL add_addr: got %0h want 0", imem_addr); end
            end
            if (rf_we === 1'b1) begin
                got++;
                n_cmp++; if (c != 4) begin n_err++; $display("FAIL add_we_cycle: got %0d want 4", c); end
                n_cmp++; if (dec_funct !== 6'h20) begin n_err++; $display("FAIL add_funct: got %0h want 20", dec_funct); end
                if (sb.size() == 0) begin n_cmp++; n_err++; $display("FAIL add_sb: got empty want entry"); end
                else begin
                    e = sb.pop_front(); retired++;
                    n_cmp++; if (ir !== e.ir) begin n_err++; $display("FAIL add_ir: got %0h want %0h", ir, e.ir); end
                    n_cmp++; if (pc !== e.pc) begin n_err++; $display("FAIL add_wbpc: got %0h want %0h", pc, e.pc); end
                end
            end
        end
        n_cmp++; if (got != 1) begin n_err++; $display("FAIL add_we_count: got %0d want 1", got); end
        n_cmp++; if (pc !== 30'd1) begin n_err++; $display("FAIL add_pc: got %0h want 1", pc); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL add_idle: got %0h want 0", busy); end
        n_cmp++; if (halt_cause !== 2'd0) begin n_err++; $display("FAIL add_cause: got %0h want 0", halt_cause); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int got = 0;
        mem[1] = 32'h01095020; mem[2] = 32'h2128000A; mem[3] = 32'h014B6020;
        imem_ready = 1'b1; stop = 1'b0;
        sb.push_back('{pc: 30'd1, ir: 32'h01095020});
        sb.push_back('{pc: 30'd2, ir: 32'h2128000A});
        start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            if (c == 1) start = 1'b0;
            if (c == 5) stop = 1'b1;
            if (rf_we === 1'b1) begin
                got++;
                n_cmp++; if (c != 4 * got) begin n_err++; $display("FAIL b2b_we_cycle: got %0d want %0d", c, 4 * got); end
                if (sb.size() == 0) begin n_cmp++; n_err++; $display("FAIL b2b_sb: got empty want entry"); end
                else begin
                    e = sb.pop_front(); retired++;
                    n_cmp++; if (ir !== e.ir) begin n_err++; $display("FAIL b2b_ir: got %0h want %0h", ir, e.ir); end
                    n_cmp++; if (pc !== e.pc) begin n_err++; $display("FAIL b2b_wbpc: got %0h want %0h", pc, e.pc); end
                end
            end
            if (c == 9) begin
                n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stop_busy: got %0h want 0", busy); end
                n_cmp++; if (pc !== 30'd3) begin n_err++; $display("FAIL stop_pc: got %0h want 3", pc); end
                n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stop_req: got %0h want 0", imem_req); end
            end
        end
        n_cmp++; if (got != 2) begin n_err++; $display("FAIL b2b_count: got %0d want 2", got); end
        sb.push_back('{pc: 30'd3, ir: 32'h014B6020});
        start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            if (c == 1) begin
                start = 1'b0;
                n_cmp++; if (imem_addr !== 30'd3 || imem_req !== 1'b1) begin n_err++; $display("FAIL resume_addr: got %0h/%0h want 3/1", imem_addr, imem_req); end
            end
            if (rf_we === 1'b1) begin
                got++;
                n_cmp++; if (c != 4) begin n_err++; $display("FAIL resume_we_cycle: got %0d want 4", c); end
                if (sb.size() == 0) begin n_cmp++; n_err++; $display("FAIL resume_sb: got empty want entry"); end
                else begin
                    e = sb.pop_front(); retired++;
                    n_cmp++; if (ir !== e.ir) begin n_err++; $display("FAIL resume_ir: got %0h want %0h", ir, e.ir); end
                end
            end
        end
        n_cmp++; if (got != 3) begin n_err++; $display("FAIL resume_count: got %0d want 3", got); end
        n_cmp++; if (pc !== 30'd4) begin n_err++; $display("FAIL resume_pc: got %0h want 4", pc); end
        n_cmp++; if (instr_count !== exp_icount(retired)) begin n_err++; $display("FAIL b2b_icount: got %0d want %0d", instr_count, exp_icount(retired)); end
    endtask

    task automatic test_wait_states();
        exp_t e;
        int got = 0;
        mem[4] = 32'h2128000A; imem_ready = 1'b0; stop = 1'b1;
        sb.push_back('{pc: 30'd4, ir: 32'h2128000A});
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (c == 1) start = 1'b0;
            if (c <= 4) begin
                n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL ws_req c%0d: got %0h want 1", c, imem_req); end
            end
            if (c == 4) begin
                n_cmp++; if (ir !== 32'h014B6020) begin n_err++; $display("FAIL ws_ir_hold: got %0h want 014b6020", ir); end
                imem_ready = 1'b1;
            end
            if (c == 5) begin
                n_cmp++; if (ir !== 32'h2128000A) begin n_err++; $display("FAIL ws_ir: got %0h want 2128000a", ir); end
            end
            if (rf_we === 1'b1) begin
                got++;
                n_cmp++; if (c != 7) begin n_err++; $display("FAIL ws_we_cycle: got %0d want 7", c); end
                if (sb.size() == 0) begin n_cmp++; n_err++; $display("FAIL ws_sb: got empty want entry"); end
                else begin
                    e = sb.pop_front(); retired++;
                    n_cmp++; if (pc !== e.pc) begin n_err++; $display("FAIL ws_wbpc: got %0h want %0h", pc, e.pc); end
                end
            end
        end
        n_cmp++; if (got != 1) begin n_err++; $display("FAIL ws_count: got %0d want 1", got); end
        n_cmp++; if (pc !== 30'd5 || halted !== 1'b0) begin n_err++; $display("FAIL ws_end: got pc %0h halted %0h want 5/0", pc, halted); end
    endtask

    task automatic test_reset_in_fetch();
        imem_ready = 1'b0; start = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            if (c == 1) start = 1'b0;
        end
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rif_pre_req: got %0h want 1", imem_req); end
        reset = 1'b1;
        @(negedge clock);
        retired = 0;
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rif_req: got %0h want 0", imem_req); end
        n_cmp++; if (pc !== 30'd0) begin n_err++; $display("FAIL rif_pc: got %0h want 0", pc); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rif_busy: got %0h want 0", busy); end
        n_cmp++; if (instr_count !== 32'd0) begin n_err++; $display("FAIL rif_icount: got %0d want 0", instr_count); end
        reset = 1'b0;
    endtask

    task automatic test_timeout();
        exp_t e;
        int got = 0;
        mem[0] = 32'h012A4020; imem_ready = 1'b1; stop = 1'b1;
        sb.push_back('{pc: 30'd0, ir: 32'h012A4020});
        start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            if (c == 1) start = 1'b0;
            if (rf_we === 1'b1) begin
                got++;
                if (sb.size() == 0) begin n_cmp++; n_err++; $display("FAIL to_sb: got empty want entry"); end
                else begin
                    e = sb.pop_front(); retired++;
                    n_cmp++; if (ir !== e.ir) begin n_err++; $display("FAIL to_ir: got %0h want %0h", ir, e.ir); end
                end
            end
        end
        n_cmp++; if (got != 1) begin n_err++; $display("FAIL to_retire: got %0d want 1", got); end
        imem_ready = 1'b0; start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (c == 1) start = 1'b0;
            if (c == 17) start = 1'b1;
            if (c == 18) start = 1'b0;
            if (c == 15) begin
                n_cmp++; if (imem_req !== 1'b1 || halted !== 1'b0) begin n_err++; $display("FAIL to_early: got req %0h halted %0h want 1/0", imem_req, halted); end
            end
            if (c == 16) begin
                n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL to_halted: got %0h want 1", halted); end
                n_cmp++; if (halt_cause !== 2'd2) begin n_err++; $display("FAIL to_cause: got %0h want 2", halt_cause); end
                n_cmp++; if (exc_pc !== 30'd1) begin n_err++; $display("FAIL to_excpc: got %0h want 1", exc_pc); end
                n_cmp++; if (imem_req !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL to_req: got req %0h busy %0h want 0/0", imem_req, busy); end
                n_cmp++; if (pc !== 30'd1) begin n_err++; $display("FAIL to_pc: got %0h want 1", pc); end
            end
        end
        n_cmp++; if (halted !== 1'b1 || imem_req !== 1'b0) begin n_err++; $display("FAIL to_sticky: got halted %0h req %0h want 1/0", halted, imem_req); end
    endtask

    task automatic test_illegal();
        int we = 0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; retired = 0;
        mem[0] = 32'hFC000000; imem_ready = 1'b1; stop = 1'b0;
        start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            if (c == 1) start = 1'b0;
            if (c == 5) start = 1'b1;
            if (c == 6) start = 1'b0;
            if (rf_we !== 1'b0) we++;
            if (c == 2) begin
                n_cmp++; if (dec_opcode !== 6'h3F || busy !== 1'b1) begin n_err++; $display("FAIL ill_decode: got op %0h busy %0h want 3f/1", dec_opcode, busy); end
            end
            if (c == 3) begin
                n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL ill_halted: got %0h want 1", halted); end
                n_cmp++; if (halt_cause !== 2'd1) begin n_err++; $display("FAIL ill_cause: got %0h want 1", halt_cause); end
                n_cmp++; if (exc_pc !== 30'd0 || pc !== 30'd0) begin n_err++; $display("FAIL ill_pc: got exc %0h pc %0h want 0/0", exc_pc, pc); end
                n_cmp++; if (ir !== 32'hFC000000) begin n_err++; $display("FAIL ill_ir: got %0h want fc000000", ir); end
            end
        end
        n_cmp++; if (we != 0) begin n_err++; $display("FAIL ill_we: got %0d want 0", we); end
        n_cmp++; if (halted !== 1'b1 || imem_req !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL ill_sticky: got halted %0h req %0h busy %0h want 1/0/0", halted, imem_req, busy); end
        n_cmp++; if (instr_count !== exp_icount(retired)) begin n_err++; $display("FAIL ill_icount: got %0d want %0d", instr_count, exp_icount(retired)); end
    endtask

    task automatic test_pc_wrap();
        int got = 0;
        mem[15] = 32'h012A4020; imem_ready = 1'b1; stop2 = 1'b1;
        start2 = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            if (c == 1) begin
                start2 = 1'b0;
                n_cmp++; if (imem_addr2 !== 4'hF) begin n_err++; $display("FAIL wrap_addr: got %0h want f", imem_addr2); end
            end
            if (rf_we2 === 1'b1) begin
                got++;
                n_cmp++; if (c != 4) begin n_err++; $display("FAIL wrap_we_cycle: got %0d want 4", c); end
                n_cmp++; if (ir2 !== 32'h012A4020 || dec_funct2 !== 6'h20) begin n_err++; $display("FAIL wrap_ir: got %0h want 012a4020", ir2); end
            end
        end
        n_cmp++; if (got != 1) begin n_err++; $display("FAIL wrap_count: got %0d want 1", got); end
        n_cmp++; if (pc2 !== 4'h0) begin n_err++; $display("FAIL wrap_pc: got %0h want 0", pc2); end
        n_cmp++; if (instr_count2 !== exp_icount(1)) begin n_err++; $display("FAIL wrap_icount: got %0d want %0d", instr_count2, exp_icount(1)); end
        imem_ready = 1'b0; start2 = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clock);
            if (c == 1) start2 = 1'b0;
        end
        n_cmp++; if (halted2 !== 1'b0 || imem_req2 !== 1'b1 || busy2 !== 1'b1) begin n_err++; $display("FAIL nowait_halt: got halted %0h req %0h busy %0h want 0/1/1", halted2, imem_req2, busy2); end
        n_cmp++; if (halt_cause2 !== 2'd0 || exc_pc2 !== 4'h0) begin n_err++; $display("FAIL nowait_cause: got %0h/%0h want 0/0", halt_cause2, exc_pc2); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        test_reset();
        test_add();
        test_back_to_back();
        test_wait_states();
        test_reset_in_fetch();
        test_timeout();
        test_illegal();
        test_pc_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
